// File: rtl/keypad_scanner.sv
// keypad_scanner: 2x4 matrix keypad scanner with per-key debounce.
// Drives one active-low column at a time and debounces each key.
//
// Parameters:
//   SCAN_DIV  - Clk cycles each column is driven (>= 4)
//   DEB_CNT   - consecutive differing samples to flip a key (2..15)
//   REP_DELAY - frames before key 1 auto-repeats (AUTOREPEAT_EN only)
//   REP_RATE  - frames between repeats of key 1 (AUTOREPEAT_EN only)
//
// Ports:
//   Clk       - clock, rising edge
//   Clr       - asynchronous active-low reset
//   col_drive - active-low column strobes, exactly one bit low
//   row_in    - active-low row returns, asynchronous to Clk
//   key_level - debounced pressed state, index = col*4 + row
//   key_pulse - one-cycle press strobes
//
// Optional feature: define AUTOREPEAT_EN to enable key 1 auto-repeat.
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEB_CNT  = 4
`ifdef AUTOREPEAT_EN
   ,
   parameter int REP_DELAY = 32,
   parameter int REP_RATE  = 8
`endif
) (
   input  logic       Clk,
   input  logic       Clr,
   output logic [1:0] col_drive,
   input  logic [3:0] row_in,
   output logic [7:0] key_level,
   output logic [7:0] key_pulse
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] LP_PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [3:0] LP_DEB_LAST = 4'(DEB_CNT - 1);

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [PW-1:0] r_pre;
   logic [1:0]    r_col_drive;
   logic [3:0]    r_deb [8];
   logic [7:0]    r_level;
   logic [7:0]    r_pulse;

   logic          w_tick;
   logic          w_col;
   logic [7:0]    w_en;
   logic [7:0]    w_samp;
   logic [7:0]    w_flip;
   logic [7:0]    w_rise;
   logic [7:0]    w_pulse_nxt;

   assign col_drive = r_col_drive;
   assign key_level = r_level;
   assign key_pulse = r_pulse;

   // Column 1 is being driven when col_drive == 2'b01.
   assign w_col  = r_col_drive[0];
   assign w_tick = (r_pre == LP_PRE_LAST);
   assign w_en   = !w_tick ? 8'h00 : (w_col ? 8'hF0 : 8'h0F);
   // Rows are active-low; both column halves see the same row lines.
   assign w_samp = ~{r_sync2, r_sync2};

   always_comb begin
      w_flip = '0;
      for (int k = 0; k < 8; k++) begin
         w_flip[k] = w_en[k]
                   && (w_samp[k] != r_level[k])
                   && (r_deb[k] == LP_DEB_LAST);
      end
   end

   assign w_rise = w_flip & w_samp;

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_sync1 <= 4'b1111;
         r_sync2 <= 4'b1111;
      end else begin
         r_sync1 <= row_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_pre       <= '0;
         r_col_drive <= 2'b10;
      end else if (w_tick) begin
         r_pre       <= '0;
         r_col_drive <= ~r_col_drive;
      end else begin
         r_pre       <= r_pre + PW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         for (int k = 0; k < 8; k++) begin
            r_deb[k] <= '0;
         end
         r_level <= '0;
         r_pulse <= '0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (w_en[k]) begin
               if ((w_samp[k] == r_level[k]) || w_flip[k]) begin
                  r_deb[k] <= '0;
               end else begin
                  r_deb[k] <= r_deb[k] + 4'd1;
               end
            end
         end
         r_level <= r_level ^ w_flip;
         r_pulse <= w_pulse_nxt;
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] LP_REP_DELAY = RW'(REP_DELAY);
   localparam logic [RW-1:0] LP_REP_RATE  = RW'(REP_RATE);

   logic [RW-1:0] r_rep_cnt;
   logic          r_rep_arm;
   logic [RW-1:0] w_rep_inc;
   logic [RW-1:0] w_rep_tgt;
   logic          w_rep_step;
   logic          w_rep_fire;

   // A frame counts toward repeat only if key 1 stays held
   // through its own sample instant.
   assign w_rep_step = w_en[1] && r_level[1] && !w_flip[1];
   assign w_rep_inc  = r_rep_cnt + RW'(1);
   // First interval is the delay, later ones the rate.
   assign w_rep_tgt  = r_rep_arm ? LP_REP_RATE : LP_REP_DELAY;
   assign w_rep_fire = w_rep_step && (w_rep_inc == w_rep_tgt);

   assign w_pulse_nxt = w_rise | {6'b0, w_rep_fire, 1'b0};

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_rep_cnt <= '0;
         r_rep_arm <= 1'b0;
      end else if (!r_level[1] || w_flip[1]) begin
         r_rep_cnt <= '0;
         r_rep_arm <= 1'b0;
      end else if (w_rep_step) begin
         if (w_rep_fire) begin
            r_rep_cnt <= '0;
            r_rep_arm <= 1'b1;
         end else begin
            r_rep_cnt <= w_rep_inc;
         end
      end
   end
`else
   assign w_pulse_nxt = w_rise;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: bench for keypad_scanner with SCAN_DIV=4, DEB_CNT=3.
// Table vectors, directed corner sequences and random rows vs a model.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 3;
`ifdef AUTOREPEAT_EN
   localparam int RD = 4;
   localparam int RR = 2;
`endif

   logic       Clk = 1'b0;
   logic       Clr = 1'b1;
   logic [1:0] col_drive;
   logic [3:0] row_in = 4'hF;
   logic [7:0] key_level;
   logic [7:0] key_pulse;

   int n_chk = 0;
   int n_err = 0;

`ifdef AUTOREPEAT_EN
   keypad_scanner #(
      .SCAN_DIV(SD), .DEB_CNT(DB), .REP_DELAY(RD), .REP_RATE(RR)
   ) dut (
      .Clk(Clk), .Clr(Clr), .col_drive(col_drive), .row_in(row_in),
      .key_level(key_level), .key_pulse(key_pulse)
   );
`else
   keypad_scanner #(
      .SCAN_DIV(SD), .DEB_CNT(DB)
   ) dut (
      .Clk(Clk), .Clr(Clr), .col_drive(col_drive), .row_in(row_in),
      .key_level(key_level), .key_pulse(key_pulse)
   );
`endif

   always #5 Clk = ~Clk;

   // Reference model: edge count since reset release, per-key level
   // and run of consecutive differing samples, frames held for key 1.
   int         m_e;
   logic [7:0] m_lvl;
   logic [7:0] m_pul;
   int         m_run [8];
   int         m_rep;
   logic [3:0] m_hist [$];

   int         st_pcnt;
   logic [7:0] st_por;
   int         pe_q [$];
   logic [7:0] pv_q [$];
   int         p1_q [$];

   typedef struct {
      logic [3:0] c0;
      logic [3:0] c1;
      int         frames;
      logic [7:0] lvl;
      int         npulse;
      logic [7:0] por;
   } vec_t;

   vec_t       tbl [8];
   logic [3:0] r0;
   logic [3:0] r1;
   logic [3:0] v;

   function automatic void model_reset();
      m_e = 0;
      m_lvl = '0;
      m_pul = '0;
      m_rep = 0;
      for (int k = 0; k < 8; k++) m_run[k] = 0;
      m_hist.delete();
   endfunction

   function automatic int cur_col();
      return (m_e / SD) % 2;
   endfunction

   function automatic void model_edge(input logic [3:0] rows);
      logic [3:0] s;
      int         col;
      int         k;
      logic       p;
`ifdef AUTOREPEAT_EN
      logic       prev1;
`endif
      m_e++;
      m_hist.push_back(rows);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      // Value seen by the logic is the one captured two edges earlier.
      s = (m_hist.size() == 3) ? m_hist[0] : 4'hF;
      m_pul = '0;
      if (m_e % SD == 0) begin
         col = ((m_e - 1) / SD) % 2;
`ifdef AUTOREPEAT_EN
         prev1 = m_lvl[1];
`endif
         for (int r = 0; r < 4; r++) begin
            k = col * 4 + r;
            p = !s[r];
            if (p != m_lvl[k]) begin
               m_run[k]++;
               if (m_run[k] == DB) begin
                  m_lvl[k] = p;
                  m_run[k] = 0;
                  m_pul[k] = p;
               end
            end else begin
               m_run[k] = 0;
            end
         end
`ifdef AUTOREPEAT_EN
         if (col == 0) begin
            if (!m_lvl[1]) begin
               m_rep = 0;
            end else if (prev1) begin
               m_rep++;
               if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0))
                  m_pul[1] = 1'b1;
            end
         end
`endif
      end
   endfunction

   task automatic chk8(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h want %02h (edge %0d)", nm, act, exp, m_e);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, m_e);
      end
   endtask

   task automatic stats_clear();
      st_pcnt = 0;
      st_por = '0;
      pe_q.delete();
      pv_q.delete();
      p1_q.delete();
   endtask

   function automatic int first_edge();
      return (pe_q.size() > 0) ? pe_q[0] : -1;
   endfunction

   function automatic logic [7:0] first_val();
      return (pv_q.size() > 0) ? pv_q[0] : 8'h00;
   endfunction

   task automatic tick(input logic [3:0] rows);
      row_in = rows;
      @(posedge Clk);
      model_edge(rows);
      #1;
      chk8("col_drive", {6'b0, col_drive}, (cur_col() == 1) ? 8'h01 : 8'h02);
      chk8("key_level", key_level, m_lvl);
      chk8("key_pulse", key_pulse, m_pul);
      if (key_pulse != 8'h00) begin
         st_pcnt += $countones(key_pulse);
         st_por |= key_pulse;
         pe_q.push_back(m_e);
         pv_q.push_back(key_pulse);
      end
      if (key_pulse[1]) p1_q.push_back(m_e);
   endtask

   task automatic run_frames(input int n, input logic [3:0] c0,
                             input logic [3:0] c1);
      for (int i = 0; i < n * 2 * SD; i++) begin
         tick((cur_col() == 1) ? c1 : c0);
      end
   endtask

   task automatic do_reset();
      Clr = 1'b0;
      row_in = 4'hF;
      #1;
      chk8("rst_col", {6'b0, col_drive}, 8'h02);
      chk8("rst_level", key_level, 8'h00);
      chk8("rst_pulse", key_pulse, 8'h00);
      @(posedge Clk);
      #1;
      chk8("rst_hold_col", {6'b0, col_drive}, 8'h02);
      Clr = 1'b1;
      model_reset();
      stats_clear();
   endtask

`ifdef AUTOREPEAT_EN
   int rep_e [5] = '{52, 68, 84, 100, 116};
`endif

   initial begin
      tbl[0] = '{c0:4'hF, c1:4'hF, frames:4, lvl:8'h00, npulse:0, por:8'h00};
      tbl[1] = '{c0:4'hF, c1:4'hB, frames:4, lvl:8'h40, npulse:1, por:8'h40};
      tbl[2] = '{c0:4'hE, c1:4'hF, frames:4, lvl:8'h01, npulse:1, por:8'h01};
      tbl[3] = '{c0:4'hE, c1:4'hE, frames:4, lvl:8'h11, npulse:2, por:8'h11};
      tbl[4] = '{c0:4'h0, c1:4'h0, frames:3, lvl:8'hFF, npulse:8, por:8'hFF};
      tbl[5] = '{c0:4'h5, c1:4'hA, frames:4, lvl:8'h5A, npulse:4, por:8'h5A};
      tbl[6] = '{c0:4'hE, c1:4'hF, frames:2, lvl:8'h00, npulse:0, por:8'h00};
      tbl[7] = '{c0:4'hF, c1:4'h7, frames:3, lvl:8'h80, npulse:1, por:8'h80};

      #2;
      for (int i = 0; i < 8; i++) begin
         do_reset();
         run_frames(tbl[i].frames, tbl[i].c0, tbl[i].c1);
         chk8($sformatf("vec%0d_level", i), key_level, tbl[i].lvl);
         chki($sformatf("vec%0d_npulse", i), st_pcnt, tbl[i].npulse);
         chk8($sformatf("vec%0d_por", i), st_por, tbl[i].por);
      end

      // Mute key: rises on 3rd column-1 sample, release needs 3 samples.
      do_reset();
      run_frames(3, 4'hF, 4'hB);
      chki("mute_edge", first_edge(), 24);
      chk8("mute_val", first_val(), 8'h40);
      chki("mute_npulse", st_pcnt, 1);
      stats_clear();
      run_frames(2, 4'hF, 4'hF);
      chk8("mute_hold", key_level, 8'h40);
      run_frames(1, 4'hF, 4'hF);
      chk8("mute_off", key_level, 8'h00);
      chki("mute_rel_npulse", st_pcnt, 0);

      // Bounce: 2 pressed, 1 released, 2 pressed never qualifies.
      do_reset();
      run_frames(2, 4'hE, 4'hF);
      run_frames(1, 4'hF, 4'hF);
      run_frames(2, 4'hE, 4'hF);
      run_frames(2, 4'hF, 4'hF);
      chk8("bounce_level", key_level, 8'h00);
      chki("bounce_npulse", st_pcnt, 0);

      // Keys 0 and 4 together: pulses one column phase apart.
      do_reset();
      run_frames(3, 4'hE, 4'hE);
      chki("dual_count", pe_q.size(), 2);
      chki("dual_e0", first_edge(), 20);
      chk8("dual_v0", first_val(), 8'h01);
      if (pe_q.size() > 1) begin
         chki("dual_e1", pe_q[1], 24);
         chk8("dual_v1", pv_q[1], 8'h10);
      end
      chk8("dual_level", key_level, 8'h11);

      // Reset mid-debounce discards the partial count.
      do_reset();
      run_frames(3, 4'hF, 4'hD);
      run_frames(2, 4'h7, 4'hD);
      chk8("pre_clr_level", key_level, 8'h20);
      do_reset();
      run_frames(2, 4'h7, 4'hF);
      chki("clr_early_npulse", st_pcnt, 0);
      run_frames(1, 4'h7, 4'hF);
      chki("clr_edge", first_edge(), 20);
      chk8("clr_val", first_val(), 8'h08);
      chk8("clr_level", key_level, 8'h08);

      // Key 1 held for 12 frames after its press pulse.
      do_reset();
      run_frames(3, 4'hD, 4'hF);
      chki("up_edge", first_edge(), 20);
      stats_clear();
      run_frames(12, 4'hD, 4'hF);
      chk8("up_level", key_level, 8'h02);
`ifdef AUTOREPEAT_EN
      chki("rep_count", p1_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < p1_q.size()) chki($sformatf("rep_e%0d", i), p1_q[i], rep_e[i]);
      end
`else
      chki("rep_count", p1_q.size(), 0);
`endif

      // Random rows with occasional single-cycle glitches.
      do_reset();
      r0 = 4'hF;
      r1 = 4'hF;
      for (int f = 0; f < 150; f++) begin
         if (f == 75) do_reset();
         if ($urandom_range(0, 2) == 0) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
         end
         for (int i = 0; i < 2 * SD; i++) begin
            v = (cur_col() == 1) ? r1 : r0;
            if ($urandom_range(0, 15) == 0) v[$urandom_range(0, 3)] ^= 1'b1;
            tick(v);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: Clk cycles each column is driven; legal range >= 4.
REQ-002 SHALL have parameter DEB_CNT, default 4: number of consecutive differing samples needed to flip a key's debounced state; legal range 2..15.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port col_drive, output, 2 bits: column strobes, active-low, exactly one bit low at all times.
REQ-006 SHALL have port row_in, input, 4 bits: row returns, active-low, asynchronous to Clk (board pull-ups).
REQ-007 SHALL have port key_level, output, 8 bits: debounced pressed state, 1 = pressed.
REQ-008 SHALL have port key_pulse, output, 8 bits: one-cycle press strobes.
REQ-009 Key index SHALL be col*4 + row. Key 0 is Next, 1 Up, 2 SetTime, 3 SetAlarm, 4 Snooze, 5 Stop, 6 Mute, 7 spare.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-012 At prescaler == SCAN_DIV-1, the synchronized rows SHALL be sampled for the currently driven column, and col_drive SHALL toggle on that same edge (10 -> 01 -> 10).
REQ-013 One full scan frame SHALL be 2*SCAN_DIV cycles, and each key SHALL be sampled exactly once per frame.
REQ-014 Each key SHALL have a debounce counter that behaves as follows:
- sample == key_level: counter cleared.
- sample != key_level and counter < DEB_CNT-1: counter incremented.
- sample != key_level and counter == DEB_CNT-1: key_level bit flips and counter cleared.
REQ-015 key_pulse[i] SHALL be high for exactly one Clk cycle, on the same registered edge where key_level[i] goes 0 -> 1; a release SHALL produce no pulse.
REQ-016 A glitch shorter than DEB_CNT consecutive samples SHALL NOT change key_level.
REQ-017 Several keys pressed together SHALL be debounced independently; pulses from the same column may coincide. No ghost-key suppression is required.
REQ-018 Debounce counters SHALL only be updated at their column's sample instant; in all other cycles they hold.

Reset
REQ-019 While Clr = 0, the block SHALL asynchronously force: col_drive = 2'b10, prescaler = 0, synchronizers = 4'b1111, all debounce counters = 0, key_level = 0, key_pulse = 0, and all repeat counters = 0.
REQ-020 Clr asserted mid-debounce or mid-repeat SHALL discard the partial count; after release, a held key SHALL need a full DEB_CNT samples before key_level reasserts.
REQ-021 The first sample after reset release SHALL occur at cycle SCAN_DIV-1, on column 0.

Configuration
REQ-022 The auto-repeat feature SHALL be controlled by macro AUTOREPEAT_EN.
REQ-023 When AUTOREPEAT_EN is defined, the block SHALL have parameters REP_DELAY (default 32) and REP_RATE (default 8), both counted in frames.
REQ-024 When AUTOREPEAT_EN is defined and key 1 (Up) remains at key_level = 1, key_pulse[1] SHALL re-fire one cycle at key 1's sample instant after REP_DELAY frames, and then every REP_RATE frames.
REQ-025 When AUTOREPEAT_EN is defined, releasing key 1 SHALL clear its repeat counter.
REQ-026 When AUTOREPEAT_EN is undefined, key_pulse[1] SHALL follow REQ-015 only, and no repeat logic or parameters SHALL exist.

Verification (SCAN_DIV=4, DEB_CNT=3, REP_DELAY=4, REP_RATE=2)
REQ-027 Reset release, no keys -> col_drive toggles every 4 cycles (10, 01, 10, ...), key_level = 0, key_pulse never asserts.
REQ-028 Hold row_in[2] low only during column-1 phases (key 6, Mute) -> key_level[6] rises on the 3rd column-1 sample, with a single key_pulse = 8'h40 on that edge; releasing for 3 samples clears the bit with no pulse.
REQ-029 Key 0 pressed for 2 samples, released 1 sample, pressed 2 samples -> key_level[0] stays 0 and no pulse.
REQ-030 Keys 0 and 4 held simultaneously -> pulses 8'h01 and 8'h10 occur 4 cycles apart, and key_level = 8'h11.
REQ-031 Clr pulsed low after 2 good samples of key 3 -> outputs are 0 immediately; after release, a key 3 pulse appears only after 3 further samples.
REQ-032 With AUTOREPEAT_EN defined, hold key 1 for 12 frames after its press pulse -> repeat pulses at frames +4, +6, +8, +10, +12; with the macro undefined -> only the initial pulse.
